// File: rtl/fifo_flush_pkg.sv
// Shared definitions for the nibble FIFO flush path (writer, FIFO, reader).
package fifo_flush_pkg;

   localparam int NIB_W      = 4;
   localparam int FIFO_DEPTH = 32;
   localparam logic [NIB_W-1:0] PAD_NIBBLE = 4'hC;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_nibble_writer.sv
// Write-side feeder for the nibble FIFO. Takes 32-bit words over valid/ready,
// serialises them LSB nibble first onto the FIFO write port, and chains
// back-to-back words with no bubble.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no word held; ready for a new word unless abort is high
//   SHIFT | word held in shreg; one nibble written per non-full cycle
module fifo_nibble_writer #(
   parameter int DATA_W = 32,
   parameter int NIB_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              wclock,
   input  logic              reset,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              in_last_i,
   output logic              in_ready_o,
   input  logic              abort_i,
   input  logic              fifo_full_i,
   output logic              fifo_wr_valid_o,
   output logic [NIB_W-1:0]  fifo_wr_data_o,
   output logic              pkt_done_o,
   output logic              busy_o,
   output logic [CNT_W-1:0]  word_count_o
);
   import fifo_flush_pkg::state_t;
   import fifo_flush_pkg::IDLE;
   import fifo_flush_pkg::SHIFT;

   localparam int NIBS  = DATA_W / NIB_W;
   localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBS - 1);

   state_t            state;
   state_t            state_nx;
   logic [DATA_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic              last_q;
   logic              pkt_done_q;
   logic [CNT_W-1:0]  word_cnt;
   logic              wr_fire;
   logic              final_write;
   logic              ready;
   logic              accept;

   // State register.
   always_ff @(posedge wclock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, write strobe and ready; abort overrides everything.
   always_comb begin
      state_nx    = state;
      wr_fire     = 1'b0;
      final_write = 1'b0;
      ready       = 1'b0;
      case (state)
         IDLE: begin
            ready = !abort_i;
            if (in_valid_i && !abort_i) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            wr_fire     = !fifo_full_i && !abort_i;
            final_write = wr_fire && (idx == IDX_LAST);
            // Ready on the last nibble lets the next word load with no bubble.
            ready       = final_write;
            if (final_write && !in_valid_i) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort_i) begin
         state_nx = IDLE;
      end
   end

   assign accept = in_valid_i && ready;

   // Shift register, nibble index, packet-end flag, done pulse and word count.
   always_ff @(posedge wclock or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         idx        <= '0;
         last_q     <= 1'b0;
         pkt_done_q <= 1'b0;
         word_cnt   <= '0;
      end else if (abort_i) begin
         // The in-flight word is dropped; the count of accepted words stands.
         shreg      <= '0;
         idx        <= '0;
         last_q     <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         pkt_done_q <= final_write && last_q;
         if (accept) begin
            shreg    <= in_data_i;
            last_q   <= in_last_i;
            idx      <= '0;
            word_cnt <= word_cnt + CNT_W'(1);
         end else if (wr_fire) begin
            shreg <= shreg >> NIB_W;
            idx   <= final_write ? '0 : idx + IDX_W'(1);
         end
      end
   end

   assign in_ready_o      = ready;
   assign fifo_wr_valid_o = wr_fire;
   assign fifo_wr_data_o  = shreg[NIB_W-1:0];
   assign pkt_done_o      = pkt_done_q;
   assign busy_o          = (state != IDLE);
   assign word_count_o    = word_cnt;

endmodule
